// File: rtl/counter_cdc_rx_if.sv
// rtl/counter_cdc_rx_if.sv - Gray counter input and decoded outputs of counter_cdc_rx
interface counter_cdc_rx_if #(
  parameter int BITS = 20
);
  logic [BITS-1:0] gray_src;
  logic            err_clr_dst;
  logic [BITS-1:0] counter_dst;
  logic [BITS-1:0] delta_dst;
  logic            valid_dst;
  logic            err_dst;

  modport master (
    output gray_src, err_clr_dst,
    input  counter_dst, delta_dst, valid_dst, err_dst
  );

  modport slave (
    input  gray_src, err_clr_dst,
    output counter_dst, delta_dst, valid_dst, err_dst
  );
endinterface

// File: rtl/counter_cdc_rx.sv
// rtl/counter_cdc_rx.sv - Gray counter CDC receiver with delta tracking; step check under COUNTER_CDC_RX_STEP_CHECK_EN
module counter_cdc_rx #(
  parameter int BITS        = 20,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_STEP    = 3
) (
  input  logic               clk_dst,
  input  logic               rst_dst_n,
  counter_cdc_rx_if.slave    bus
);

  localparam int FW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {S_FLUSH, S_LOAD, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [BITS-1:0] sync_q [SYNC_STAGES];
  logic [BITS-1:0] gray_s;
  logic [BITS-1:0] bin_d, bin_q;
  logic [BITS-1:0] counter_q, counter_d;
  logic [BITS-1:0] delta_q, delta_d;
  logic [BITS-1:0] delta;
  logic            valid_q, valid_d;
  logic            err_q;

  assign gray_s = sync_q[SYNC_STAGES-1];
  assign delta  = bin_q - counter_q;

  // synchronizer chain for the asynchronous Gray bus
  always_ff @(posedge clk_dst or negedge rst_dst_n) begin
    if (!rst_dst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.gray_src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Gray to binary: each bit is the XOR of all Gray bits at or above it
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < BITS; i++) bin_d[i] = ^(gray_s >> i);
  end

  // state, flush counter, decoded sample and output registers
  always_ff @(posedge clk_dst or negedge rst_dst_n) begin
    if (!rst_dst_n) begin
      state_q   <= S_FLUSH;
      flush_q   <= '0;
      bin_q     <= '0;
      counter_q <= '0;
      delta_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      bin_q     <= bin_d;
      counter_q <= counter_d;
      delta_q   <= delta_d;
      valid_q   <= valid_d;
    end
  end

  // flush until the pipeline holds real data, load once, then track changes
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    counter_d = counter_q;
    delta_d   = delta_q;
    valid_d   = 1'b0;
    unique case (state_q)
      S_FLUSH: begin
        if (flush_q == FW'(SYNC_STAGES)) state_d = S_LOAD;
        else                             flush_d = flush_q + FW'(1);
      end
      S_LOAD: begin
        counter_d = bin_q;
        delta_d   = '0;
        valid_d   = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (delta != '0) begin
          counter_d = bin_q;
          delta_d   = delta;
          valid_d   = 1'b1;
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

`ifdef COUNTER_CDC_RX_STEP_CHECK_EN
  logic step_bad;

  // a backward step shows up as a huge modulo delta and trips this too
  assign step_bad = (state_q == S_RUN) && (delta > BITS'(MAX_STEP));

  // sticky error; a new violation beats a simultaneous clear
  always_ff @(posedge clk_dst or negedge rst_dst_n) begin
    if (!rst_dst_n)           err_q <= 1'b0;
    else if (step_bad)        err_q <= 1'b1;
    else if (bus.err_clr_dst) err_q <= 1'b0;
  end
`else
  assign err_q = 1'b0;
`endif

  assign bus.counter_dst = counter_q;
  assign bus.delta_dst   = delta_q;
  assign bus.valid_dst   = valid_q;
  assign bus.err_dst     = err_q;

endmodule
